unified_mem_responder: RTL and testbench
========================================

# unified_mem_responder

Cycle-accurate responder for the CPU's instruction- and data-cache request ports. It serves both ports from one single-ported word memory with programmable access latency, serializing the two ports. It holds the shared `stall` line high while any accepted request is outstanding. It sits below `MIPS150`, driving `instruction`, `dcache_dout` and `stall` in place of the cache subsystem for integration and bring-up.

## Interface
- `ADDR_WIDTH`, 12: word-address bits; memory holds 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, 2: cycles per memory access, ≥1.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `icache_addr`  in  32  instruction byte address.
- `icache_re`  in  1  instruction read request.
- `icache_we`  in  4  instruction-port byte write enables (bit i → byte lane i, bits [8i+7:8i]).
- `icache_din`  in  32  instruction-port write data.
- `dcache_addr`  in  32  data byte address.
- `dcache_re`  in  1  data read request.
- `dcache_we`  in  4  data-port byte write enables.
- `dcache_din`  in  32  data-port write data.
- `instruction`  out  32  registered instruction-port read data.
- `dcache_dout`  out  32  registered data-port read data.
- `stall`  out  1  high while a request is in service.

## Operation
- Word index for each port is `addr[ADDR_WIDTH+1:2]`. `addr[1:0]` and the upper bits are ignored, so addresses beyond the memory size alias (wrap).
- A port is "active" when its `re` is set or its `we` is nonzero.
- FSM states: IDLE, D_BUSY, I_BUSY. `stall` = (state != IDLE), a combinational decode of registered state.
- Request acceptance: on a rising edge in IDLE with either port active, capture the active flags, addresses, `we`, `din` and `re` of both ports into request registers.
  - Go to D_BUSY if the data port is active, otherwise I_BUSY.
  - Load the down-counter with LATENCY-1.
  - Port inputs are ignored outside IDLE.
- BUSY states: the counter decrements each cycle. On the edge where counter==0, the access completes:
  - Read-before-write: the read result is the word before this access's write.
  - Read result loads into `dcache_dout` (D_BUSY) or `instruction` (I_BUSY) only if that port's captured `re` is set.
  - Byte lanes with the captured `we` bit set are written with the corresponding `din` bytes.
- Transitions on completion:
  - D_BUSY → I_BUSY (counter reloaded to LATENCY-1) if the instruction port was captured active.
  - Otherwise D_BUSY → IDLE; I_BUSY → IDLE.
- Same-word collision: a data write and an instruction read captured together at the same word give the instruction read the post-write data, because the data access is serviced first.
- Output hold: `instruction` and `dcache_dout` retain their last values until overwritten by a completing read of their own port. Accesses without `re` leave the read output unchanged.
- Reset:
  - Clears state to IDLE, the counter to 0, the request registers, `instruction` to 0 and `dcache_dout` to 0.
  - `stall` is 0 during and after reset.
  - A reset mid-access drops the access; a pending write does not occur.
  - Memory contents are not reset and are undefined until written.

## Timing
- Acceptance edge E0: `stall` rises in the cycle after E0.
- Single-port access: completes on edge E0+LATENCY. `stall` is high for exactly LATENCY cycles, and read data is visible in the first cycle `stall` is low.
- Dual-port access: `stall` is high for 2×LATENCY cycles. Data completes at E0+LATENCY, instruction at E0+2×LATENCY.
- Back-to-back: a new request can be accepted on the same edge at which `stall` is first observed low, i.e. the cycle after completion. There is no forced idle cycle beyond that.
- The CPU must hold requests stable only in the accept cycle; the block does not depend on inputs held during `stall`.

## Test plan
- Reset: assert `rst` 2 cycles with ports active → `stall`=0, `instruction`=0, `dcache_dout`=0 throughout; no memory write.
- Full-word data write then read, LATENCY=2:
  - Write `dcache_we`=4'hF, addr 0x10, din 0xDEADBEEF → `stall` high exactly 2 cycles.
  - Then `dcache_re` at 0x10 → `dcache_dout`=0xDEADBEEF after 2 stall cycles.
- Byte lanes:
  - Write 0xFFFFFFFF to 0x20, then `we`=4'b0101 with din 0x11223344.
  - Read → 0xFF22FF44.
  - Read with addr 0x23 → same word.
- Dual request:
  - Same cycle: `icache_re` at 0x20 plus data write 0xCAFEF00D to 0x20.
  - Required response: `stall` high 4 cycles, then `instruction`=0xCAFEF00D and `dcache_dout` unchanged.
- Aliasing: ADDR_WIDTH=12, write 0x1234 to 0x4008 → read at 0x0008 returns 0x1234.
- Reset mid-access: assert `rst` in the 1st stall cycle of a write of 0xAAAA5555 to 0x30 → `stall`=0 next cycle; a later read of 0x30 returns the prior contents.

Source files
------------

// File: rtl/unified_mem_responder.sv
// unified_mem_responder: serves the instruction and data request ports from one
// single-ported word memory with a fixed access latency. Data requests go first.
// Stall stays high while an accepted request is outstanding.
module unified_mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] icache_addr,
  input  logic        icache_re,
  input  logic [3:0]  icache_we,
  input  logic [31:0] icache_din,
  input  logic [31:0] dcache_addr,
  input  logic        dcache_re,
  input  logic [3:0]  dcache_we,
  input  logic [31:0] dcache_din,
  output logic [31:0] instruction,
  output logic [31:0] dcache_dout,
  output logic        stall
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY} state_t;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  d_act_q, d_act_d, i_act_q, i_act_d;
  logic                  d_re_q, d_re_d, i_re_q, i_re_d;
  logic [3:0]            d_we_q, d_we_d, i_we_q, i_we_d;
  logic [ADDR_WIDTH-1:0] d_idx_q, d_idx_d, i_idx_q, i_idx_d;
  logic [31:0]           d_din_q, d_din_d, i_din_q, i_din_d;
  logic [31:0]           instruction_q, instruction_d;
  logic [31:0]           dcache_dout_q, dcache_dout_d;

  logic                  d_active, i_active;
  logic [ADDR_WIDTH-1:0] mem_idx;
  logic [31:0]           mem_wdata;
  logic [31:0]           rd_word;
  logic [3:0]            mem_we;

  // Only the word-index bits of each address matter; the rest alias away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{icache_addr[31:ADDR_WIDTH+2], icache_addr[1:0],
                              dcache_addr[31:ADDR_WIDTH+2], dcache_addr[1:0]};

  assign d_active  = dcache_re | (|dcache_we);
  assign i_active  = icache_re | (|icache_we);
  assign mem_idx   = (state_q == D_BUSY) ? d_idx_q : i_idx_q;
  assign mem_wdata = (state_q == D_BUSY) ? d_din_q : i_din_q;
  assign rd_word   = mem[mem_idx];

  // Next-state logic: capture both ports in IDLE, count down, then complete data before instruction.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    d_act_d       = d_act_q;
    i_act_d       = i_act_q;
    d_re_d        = d_re_q;
    i_re_d        = i_re_q;
    d_we_d        = d_we_q;
    i_we_d        = i_we_q;
    d_idx_d       = d_idx_q;
    i_idx_d       = i_idx_q;
    d_din_d       = d_din_q;
    i_din_d       = i_din_q;
    instruction_d = instruction_q;
    dcache_dout_d = dcache_dout_q;
    mem_we        = 4'b0000;
    case (state_q)
      IDLE: begin
        if (d_active || i_active) begin
          d_act_d = d_active;
          i_act_d = i_active;
          d_re_d  = dcache_re;
          i_re_d  = icache_re;
          d_we_d  = dcache_we;
          i_we_d  = icache_we;
          d_idx_d = dcache_addr[ADDR_WIDTH+1:2];
          i_idx_d = icache_addr[ADDR_WIDTH+1:2];
          d_din_d = dcache_din;
          i_din_d = icache_din;
          state_d = d_active ? D_BUSY : I_BUSY;
          cnt_d   = RELOAD;
        end
      end
      D_BUSY: begin
        if (cnt_q == '0) begin
          if (d_re_q) dcache_dout_d = rd_word;
          mem_we = d_we_q;
          if (i_act_q) begin
            state_d = I_BUSY;
            cnt_d   = RELOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      I_BUSY: begin
        if (cnt_q == '0) begin
          if (i_re_q) instruction_d = rd_word;
          mem_we  = i_we_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      d_act_q       <= 1'b0;
      i_act_q       <= 1'b0;
      d_re_q        <= 1'b0;
      i_re_q        <= 1'b0;
      d_we_q        <= 4'b0000;
      i_we_q        <= 4'b0000;
      d_idx_q       <= '0;
      i_idx_q       <= '0;
      d_din_q       <= '0;
      i_din_q       <= '0;
      instruction_q <= '0;
      dcache_dout_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      d_act_q       <= d_act_d;
      i_act_q       <= i_act_d;
      d_re_q        <= d_re_d;
      i_re_q        <= i_re_d;
      d_we_q        <= d_we_d;
      i_we_q        <= i_we_d;
      d_idx_q       <= d_idx_d;
      i_idx_q       <= i_idx_d;
      d_din_q       <= d_din_d;
      i_din_q       <= i_din_d;
      instruction_q <= instruction_d;
      dcache_dout_q <= dcache_dout_d;
    end
  end

  // Byte-lane memory write on completion; a reset on that edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign stall       = (state_q != IDLE);
  assign instruction = instruction_q;
  assign dcache_dout = dcache_dout_q;

endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed testbench for unified_mem_responder with hand-computed expected values.
module tb_unified_mem_responder;

   logic        clk;
   logic        rst;
   logic [31:0] icache_addr;
   logic        icache_re;
   logic [3:0]  icache_we;
   logic [31:0] icache_din;
   logic [31:0] dcache_addr;
   logic        dcache_re;
   logic [3:0]  dcache_we;
   logic [31:0] dcache_din;
   logic [31:0] instruction;
   logic [31:0] dcache_dout;
   logic        stall;

   int errors = 0;
   int checks = 0;
   int nStall;

   unified_mem_responder #(.ADDR_WIDTH(12), .LATENCY(2)) dut (
      .clk(clk),
      .rst(rst),
      .icache_addr(icache_addr),
      .icache_re(icache_re),
      .icache_we(icache_we),
      .icache_din(icache_din),
      .dcache_addr(dcache_addr),
      .dcache_re(dcache_re),
      .dcache_we(dcache_we),
      .dcache_din(dcache_din),
      .instruction(instruction),
      .dcache_dout(dcache_dout),
      .stall(stall)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it if the observed value differs.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drop all port requests to the inactive state.
   task automatic clearPorts();
      icache_addr = '0; icache_re = 1'b0; icache_we = 4'h0; icache_din = '0;
      dcache_addr = '0; dcache_re = 1'b0; dcache_we = 4'h0; dcache_din = '0;
   endtask

   // Present one request at a negedge, hold it for the accept edge only, then count stall cycles.
   task automatic applyStimulus(input logic dre, input logic [3:0] dwe, input logic [31:0] daddr,
                                input logic [31:0] ddin, input logic ire, input logic [3:0] iwe,
                                input logic [31:0] iaddr, input logic [31:0] idin,
                                output int stallCycles);
      dcache_re = dre; dcache_we = dwe; dcache_addr = daddr; dcache_din = ddin;
      icache_re = ire; icache_we = iwe; icache_addr = iaddr; icache_din = idin;
      @(posedge clk);
      #1 clearPorts();
      stallCycles = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!stall) break;
         stallCycles++;
      end
   endtask

   // Directed sequence; every check is made at a negedge.
   initial begin
      rst = 1'b1;
      clearPorts();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_stall", {31'd0, stall}, 32'd0);
      checkOutput("reset_instr", instruction, 32'd0);
      checkOutput("reset_dout", dcache_dout, 32'd0);
      rst = 1'b0;

      // Full-word data write then read.
      applyStimulus(1'b0, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 4'h0, 0, 0, nStall);
      checkOutput("wr10_stall", 32'(nStall), 32'd2);
      checkOutput("wr10_dout_hold", dcache_dout, 32'd0);
      applyStimulus(1'b1, 4'h0, 32'h10, 0, 1'b0, 4'h0, 0, 0, nStall);
      checkOutput("rd10_stall", 32'(nStall), 32'd2);
      checkOutput("rd10_dout", dcache_dout, 32'hDEADBEEF);
      checkOutput("rd10_instr_hold", instruction, 32'd0);

      // Byte-lane merge and low address bits ignored.
      applyStimulus(1'b0, 4'hF, 32'h20, 32'hFFFFFFFF, 1'b0, 4'h0, 0, 0, nStall);
      applyStimulus(1'b0, 4'b0101, 32'h20, 32'h11223344, 1'b0, 4'h0, 0, 0, nStall);
      applyStimulus(1'b1, 4'h0, 32'h20, 0, 1'b0, 4'h0, 0, 0, nStall);
      checkOutput("bytes_rd20", dcache_dout, 32'hFF22FF44);
      applyStimulus(1'b1, 4'h0, 32'h23, 0, 1'b0, 4'h0, 0, 0, nStall);
      checkOutput("bytes_rd23", dcache_dout, 32'hFF22FF44);

      // Dual request at the same word: data write lands before the instruction read.
      applyStimulus(1'b0, 4'hF, 32'h20, 32'hCAFEF00D, 1'b1, 4'h0, 32'h20, 0, nStall);
      checkOutput("dual_stall", 32'(nStall), 32'd4);
      checkOutput("dual_instr", instruction, 32'hCAFEF00D);
      checkOutput("dual_dout_hold", dcache_dout, 32'hFF22FF44);

      // Read-before-write on a combined data read/write of one word.
      applyStimulus(1'b1, 4'hF, 32'h20, 32'h01020304, 1'b0, 4'h0, 0, 0, nStall);
      checkOutput("rbw_dout", dcache_dout, 32'hCAFEF00D);
      applyStimulus(1'b1, 4'h0, 32'h20, 0, 1'b0, 4'h0, 0, 0, nStall);
      checkOutput("rbw_after", dcache_dout, 32'h01020304);

      // Instruction port alone: write then read, data output untouched.
      applyStimulus(1'b0, 4'h0, 0, 0, 1'b0, 4'hF, 32'h50, 32'h600DCAFE, nStall);
      checkOutput("iwr_stall", 32'(nStall), 32'd2);
      applyStimulus(1'b0, 4'h0, 0, 0, 1'b1, 4'h0, 32'h50, 0, nStall);
      checkOutput("ird_stall", 32'(nStall), 32'd2);
      checkOutput("ird_instr", instruction, 32'h600DCAFE);
      checkOutput("ird_dout_hold", dcache_dout, 32'h01020304);

      // Dual reads of different words.
      applyStimulus(1'b1, 4'h0, 32'h10, 0, 1'b1, 4'h0, 32'h50, 0, nStall);
      checkOutput("dualrd_stall", 32'(nStall), 32'd4);
      checkOutput("dualrd_dout", dcache_dout, 32'hDEADBEEF);
      checkOutput("dualrd_instr", instruction, 32'h600DCAFE);

      // Aliasing beyond the memory size.
      applyStimulus(1'b0, 4'hF, 32'h4008, 32'h00001234, 1'b0, 4'h0, 0, 0, nStall);
      applyStimulus(1'b1, 4'h0, 32'h0008, 0, 1'b0, 4'h0, 0, 0, nStall);
      checkOutput("alias_rd", dcache_dout, 32'h00001234);

      // Reset held two cycles with both ports active: outputs clear, no write happens.
      applyStimulus(1'b0, 4'hF, 32'h40, 32'h13579BDF, 1'b0, 4'h0, 0, 0, nStall);
      rst = 1'b1;
      dcache_we = 4'hF; dcache_addr = 32'h40; dcache_din = 32'hFFFFFFFF; icache_re = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checkOutput("rst2_stall", {31'd0, stall}, 32'd0);
         checkOutput("rst2_instr", instruction, 32'd0);
         checkOutput("rst2_dout", dcache_dout, 32'd0);
      end
      rst = 1'b0;
      clearPorts();
      applyStimulus(1'b1, 4'h0, 32'h40, 0, 1'b0, 4'h0, 0, 0, nStall);
      checkOutput("rst2_nowrite", dcache_dout, 32'h13579BDF);

      // Reset in the first stall cycle of a write drops that write.
      applyStimulus(1'b0, 4'hF, 32'h30, 32'h0BADF00D, 1'b0, 4'h0, 0, 0, nStall);
      dcache_we = 4'hF; dcache_addr = 32'h30; dcache_din = 32'hAAAA5555;
      @(posedge clk);
      #1 clearPorts();
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_busy", {31'd0, stall}, 32'd1);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_stall", {31'd0, stall}, 32'd0);
      applyStimulus(1'b1, 4'h0, 32'h30, 0, 1'b0, 4'h0, 0, 0, nStall);
      checkOutput("midrst_rd", dcache_dout, 32'h0BADF00D);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
